// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types and constants used by the LL/SC unit
//
// Purpose: holds the LL/SC link state enum and the SC write-back constants
// shared across the core. Also provides the default data-path word-address
// width macro when no core-wide header has supplied one.
// Ports: none (package).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core;

  typedef enum logic {
    LLSC_UNLINKED = 1'b0,
    LLSC_LINKED   = 1'b1
  } llsc_state_t;

  localparam logic [31:0] LLSC_SC_OK   = 32'd1;
  localparam logic [31:0] LLSC_SC_FAIL = 32'd0;

endpackage

// File: rtl/llsc_input_ifc.sv
// rtl/llsc_input_ifc.sv - EX-stage load-linked / store-conditional request bundle
//
// Purpose: carries the decoded memory-op flags and effective address from EX.
// Signals:
//   is_sw      - op is a plain store word
//   lladdr_wr  - op is a load-linked (writes the link address)
//   is_sc      - op is a store-conditional
//   wr_reg_val - zero-extended effective address
// Modports: in (consumer), out (producer).

interface llsc_input_ifc;
  logic        is_sw;
  logic        lladdr_wr;
  logic        is_sc;
  logic [31:0] wr_reg_val;

  modport in  (input  is_sw, lladdr_wr, is_sc, wr_reg_val);
  modport out (output is_sw, lladdr_wr, is_sc, wr_reg_val);
endinterface

// File: rtl/llsc_link_timer.sv
// rtl/llsc_link_timer.sv - saturating age counter that expires a live link
//
// Purpose: counts cycles while a link is live and flags the cycle in which the
// link reaches its lifetime, so the owner can drop the link on that edge.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   i_clear   - restart the count (new link taken)
//   i_enable  - link is live, advance the count
//   o_expired - combinational: link must drop at the coming edge

module llsc_link_timer #(
  parameter int LINK_TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (LINK_TIMEOUT < 2) ? 1 : $clog2(LINK_TIMEOUT + 1);
  // With no timeout the counter still saturates so it never wraps.
  localparam logic [CW-1:0] C_SAT = (LINK_TIMEOUT == 0) ? {CW{1'b1}} : CW'(LINK_TIMEOUT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != C_SAT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  generate
    if (LINK_TIMEOUT == 0) begin : g_never
      assign o_expired = 1'b0;
    end else begin : g_expire
      // Flag the cycle whose edge brings the count to LINK_TIMEOUT, so the
      // link is already gone in the first cycle that sees that count.
      assign o_expired = i_enable && (r_count == CW'(LINK_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/llsc_unit.sv
// rtl/llsc_unit.sv - load-linked / store-conditional link tracker
//
// Purpose: tracks a single LL reservation (UNLINKED/LINKED), decides whether an
// SC in EX may commit, and returns the SC rt write-back value one cycle later.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   i_llsc_input   - EX op flags and effective address
//   i_valid        - EX op is real and advancing
//   i_flush        - pipeline flush / exception, kills the link
//   o_sc_valid     - one-cycle pulse after an accepted SC
//   o_sc_result    - SC write-back value (1 success, 0 failure)
//   o_sc_success   - combinational: SC in EX may commit its store
//   o_link_valid   - link is live
//   o_link_addr    - registered link address

module llsc_unit
  import mips_core::*;
#(
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int LINK_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  llsc_input_ifc.in             i_llsc_input,
  input  logic                  i_valid,
  input  logic                  i_flush,
  output logic                  o_sc_valid,
  output logic [31:0]           o_sc_result,
  output logic                  o_sc_success,
  output logic                  o_link_valid,
  output logic [ADDR_WIDTH-1:0] o_link_addr
);

  llsc_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_link_addr;
  logic                  r_sc_valid;
  logic [31:0]           r_sc_result;

  logic                  w_op_ok;
  logic                  w_is_sc;
  logic                  w_is_ll;
  logic                  w_is_sw;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_match;
  logic                  w_linked;
  logic                  w_sc_success;
  logic                  w_expired;

  // Decode priority: flush > SC > LL > SW; nothing counts without i_valid.
  assign w_op_ok  = i_valid && !i_flush;
  assign w_is_sc  = w_op_ok && i_llsc_input.is_sc;
  assign w_is_ll  = w_op_ok && !i_llsc_input.is_sc && i_llsc_input.lladdr_wr;
  assign w_is_sw  = w_op_ok && !i_llsc_input.is_sc && !i_llsc_input.lladdr_wr
                    && i_llsc_input.is_sw;

  assign w_addr   = i_llsc_input.wr_reg_val[ADDR_WIDTH-1:0];
  // Word-granular match: byte offset bits are ignored.
  assign w_match  = (w_addr[ADDR_WIDTH-1:2] == r_link_addr[ADDR_WIDTH-1:2]);
  assign w_linked = (r_state == LLSC_LINKED);

  // Expiry in the SC cycle does not stop the SC: the link is still live now.
  assign w_sc_success = w_is_sc && w_linked && w_match;

  llsc_link_timer #(
    .LINK_TIMEOUT(LINK_TIMEOUT)
  ) u_link_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_is_ll),
    .i_enable  (w_linked),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LLSC_UNLINKED;
      r_link_addr <= '0;
      r_sc_valid  <= 1'b0;
      r_sc_result <= LLSC_SC_FAIL;
    end else begin
      r_sc_valid <= w_is_sc;
      if (w_is_sc) begin
        r_sc_result <= w_sc_success ? LLSC_SC_OK : LLSC_SC_FAIL;
      end

      if (i_flush) begin
        r_state <= LLSC_UNLINKED;
      end else if (w_is_sc) begin
        r_state <= LLSC_UNLINKED;
      end else if (w_is_ll) begin
        // LL outranks a coinciding expiry; the timer is cleared alongside.
        r_state     <= LLSC_LINKED;
        r_link_addr <= w_addr;
      end else if (w_is_sw && w_match) begin
        r_state <= LLSC_UNLINKED;
      end else if (w_expired) begin
        r_state <= LLSC_UNLINKED;
      end
    end
  end

  assign o_sc_valid   = r_sc_valid;
  assign o_sc_result  = r_sc_result;
  assign o_sc_success = w_sc_success;
  assign o_link_valid = w_linked;
  assign o_link_addr  = r_link_addr;

endmodule

// File: tb/tb_llsc_unit.sv
// tb/tb_llsc_unit.sv - self-checking bench for llsc_unit

module tb_llsc_unit;

  localparam int LT = 4;

  typedef enum {K_IDLE, K_LL, K_SC, K_SW, K_FLUSH} kind_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_flush;
  logic        o_sc_valid;
  logic [31:0] o_sc_result;
  logic        o_sc_success;
  logic        o_link_valid;
  logic [31:0] o_link_addr;

  llsc_input_ifc u_if ();

  llsc_unit #(
    .ADDR_WIDTH   (32),
    .LINK_TIMEOUT (LT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_llsc_input (u_if),
    .i_valid      (i_valid),
    .i_flush      (i_flush),
    .o_sc_valid   (o_sc_valid),
    .o_sc_result  (o_sc_result),
    .o_sc_success (o_sc_success),
    .o_link_valid (o_link_valid),
    .o_link_addr  (o_link_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: one reservation with an age in cycles since the LL.
  logic        m_linked = 1'b0;
  logic [31:0] m_addr = 32'h0;
  int          m_age = 0;
  logic        m_sc_valid = 1'b0;
  logic [31:0] m_sc_result = 32'h0;

  logic got_s;
  logic exp_s;
  logic cyc_rst;

  task automatic drive(input logic r, input logic f, input logic v, input logic sc,
                       input logic ll, input logic sw, input logic [31:0] a);
    rst            = r;
    i_flush        = f;
    i_valid        = v;
    u_if.is_sc     = sc;
    u_if.lladdr_wr = ll;
    u_if.is_sw     = sw;
    u_if.wr_reg_val = a;
  endtask

  // Advance one cycle: capture the combinational success mid-cycle, then apply
  // the LL/SC rules to the model for the edge.
  task automatic tick();
    logic r, f, v, sc, ll, sw, same_word;
    logic [31:0] a;
    @(negedge clk);
    r  = rst; f = i_flush; v = i_valid;
    sc = u_if.is_sc; ll = u_if.lladdr_wr; sw = u_if.is_sw; a = u_if.wr_reg_val;
    same_word = (a[31:2] == m_addr[31:2]);
    got_s   = o_sc_success;
    exp_s   = !f && v && sc && m_linked && same_word;
    cyc_rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_linked = 1'b0; m_addr = 32'h0; m_age = 0;
      m_sc_valid = 1'b0; m_sc_result = 32'h0;
    end else begin
      m_sc_valid = !f && v && sc;
      if (m_sc_valid) m_sc_result = exp_s ? 32'd1 : 32'd0;
      if (f || (v && sc)) begin
        m_linked = 1'b0;
      end else if (v && ll) begin
        m_linked = 1'b1; m_addr = a; m_age = 0;
      end else if (v && sw && m_linked && same_word) begin
        m_linked = 1'b0;
      end else if (m_linked) begin
        m_age = m_age + 1;
        if (LT != 0 && m_age >= LT) m_linked = 1'b0;
      end
    end
  endtask

  task automatic op(input kind_t k, input logic [31:0] a);
    case (k)
      K_LL:    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
      K_SC:    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a);
      K_SW:    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a);
      K_FLUSH: drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a);
      default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    endcase
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checks++; if (o_link_valid !== 1'b0) begin failures++; $display("FAIL reset_link_valid got=%0b exp=0", o_link_valid); end
    checks++; if (o_link_addr !== 32'h0) begin failures++; $display("FAIL reset_link_addr got=%0h exp=0", o_link_addr); end
    checks++; if (o_sc_valid !== 1'b0) begin failures++; $display("FAIL reset_sc_valid got=%0b exp=0", o_sc_valid); end
    checks++; if (o_sc_result !== 32'h0) begin failures++; $display("FAIL reset_sc_result got=%0h exp=0", o_sc_result); end
    op(K_SC, 32'h0);
    checks++; if (got_s !== 1'b0) begin failures++; $display("FAIL post_reset_sc_success got=%0b exp=0", got_s); end
    checks++; if (o_sc_result !== 32'h0) begin failures++; $display("FAIL post_reset_sc_result got=%0h exp=0", o_sc_result); end
  endtask

  task automatic test_match_pair();
    op(K_LL, 32'h100);
    checks++; if (o_link_addr !== 32'h100) begin failures++; $display("FAIL pair_link_addr got=%0h exp=100", o_link_addr); end
    op(K_IDLE, 32'h0);
    op(K_SC, 32'h100);
    checks++; if (got_s !== 1'b1) begin failures++; $display("FAIL pair_sc_success got=%0b exp=1", got_s); end
    checks++; if (o_sc_valid !== 1'b1) begin failures++; $display("FAIL pair_sc_valid got=%0b exp=1", o_sc_valid); end
    checks++; if (o_sc_result !== 32'd1) begin failures++; $display("FAIL pair_sc_result got=%0h exp=1", o_sc_result); end
    checks++; if (o_link_valid !== 1'b0) begin failures++; $display("FAIL pair_link_after got=%0b exp=0", o_link_valid); end
    op(K_IDLE, 32'h0);
    checks++; if (o_sc_valid !== 1'b0) begin failures++; $display("FAIL pair_sc_valid_drop got=%0b exp=0", o_sc_valid); end
  endtask

  task automatic test_store_kill();
    logic [31:0] sw_addr [2] = '{32'h102, 32'h104};
    logic [31:0] want    [2] = '{32'd0, 32'd1};
    for (int i = 0; i < 2; i++) begin
      op(K_LL, 32'h100);
      op(K_SW, sw_addr[i]);
      op(K_SC, 32'h100);
      checks++; if (got_s !== want[i][0]) begin failures++; $display("FAIL store_kill_success[%0d] got=%0b exp=%0b", i, got_s, want[i][0]); end
      checks++; if (o_sc_result !== want[i]) begin failures++; $display("FAIL store_kill_result[%0d] got=%0h exp=%0h", i, o_sc_result, want[i]); end
    end
  endtask

  task automatic test_timeout();
    int          idles [2] = '{4, 3};
    logic [31:0] want  [2] = '{32'd0, 32'd1};
    for (int i = 0; i < 2; i++) begin
      op(K_LL, 32'h200);
      for (int j = 0; j < idles[i]; j++) op(K_IDLE, 32'h0);
      op(K_SC, 32'h200);
      checks++; if (o_sc_valid !== 1'b1) begin failures++; $display("FAIL timeout_sc_valid[%0d] got=%0b exp=1", i, o_sc_valid); end
      checks++; if (o_sc_result !== want[i]) begin failures++; $display("FAIL timeout_result[%0d] got=%0h exp=%0h", i, o_sc_result, want[i]); end
    end
  endtask

  task automatic test_ll_beats_timeout();
    op(K_LL, 32'h600);
    for (int j = 0; j < LT - 1; j++) op(K_IDLE, 32'h0);
    op(K_LL, 32'h640);
    checks++; if (o_link_valid !== 1'b1) begin failures++; $display("FAIL ll_vs_timeout_link got=%0b exp=1", o_link_valid); end
    checks++; if (o_link_addr !== 32'h640) begin failures++; $display("FAIL ll_vs_timeout_addr got=%0h exp=640", o_link_addr); end
    for (int j = 0; j < LT - 1; j++) op(K_IDLE, 32'h0);
    op(K_SC, 32'h640);
    checks++; if (o_sc_result !== 32'd1) begin failures++; $display("FAIL ll_vs_timeout_result got=%0h exp=1", o_sc_result); end
  endtask

  task automatic test_flush();
    op(K_LL, 32'h300);
    op(K_FLUSH, 32'h0);
    checks++; if (o_link_valid !== 1'b0) begin failures++; $display("FAIL flush_link got=%0b exp=0", o_link_valid); end
    op(K_SC, 32'h300);
    checks++; if (o_sc_result !== 32'd0) begin failures++; $display("FAIL flush_sc_result got=%0h exp=0", o_sc_result); end
    op(K_LL, 32'h300);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
    tick();
    checks++; if (got_s !== 1'b0) begin failures++; $display("FAIL flush_with_sc_success got=%0b exp=0", got_s); end
    checks++; if (o_link_valid !== 1'b0) begin failures++; $display("FAIL flush_with_sc_link got=%0b exp=0", o_link_valid); end
  endtask

  task automatic test_reset_mid_link();
    op(K_LL, 32'h400);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400);
    tick();
    checks++; if (o_sc_valid !== 1'b0) begin failures++; $display("FAIL rst_sc_valid got=%0b exp=0", o_sc_valid); end
    checks++; if (o_link_valid !== 1'b0) begin failures++; $display("FAIL rst_link got=%0b exp=0", o_link_valid); end
    op(K_IDLE, 32'h0);
    checks++; if (o_sc_valid !== 1'b0) begin failures++; $display("FAIL rst_sc_valid_late got=%0b exp=0", o_sc_valid); end
    op(K_SC, 32'h400);
    checks++; if (got_s !== 1'b0) begin failures++; $display("FAIL rst_later_sc_success got=%0b exp=0", got_s); end
    checks++; if (o_sc_result !== 32'd0) begin failures++; $display("FAIL rst_later_sc_result got=%0h exp=0", o_sc_result); end
  endtask

  task automatic test_gating();
    op(K_LL, 32'h500);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500);
    tick();
    checks++; if (got_s !== 1'b0) begin failures++; $display("FAIL gate_success got=%0b exp=0", got_s); end
    checks++; if (o_sc_valid !== 1'b0) begin failures++; $display("FAIL gate_sc_valid got=%0b exp=0", o_sc_valid); end
    checks++; if (o_link_valid !== 1'b1) begin failures++; $display("FAIL gate_link got=%0b exp=1", o_link_valid); end
  endtask

  task automatic test_random();
    logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h102, 32'h208};
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
            pool[$urandom_range(0, 3)]);
      tick();
      if (!cyc_rst) begin
        checks++; if (got_s !== exp_s) begin failures++; $display("FAIL rnd_success n=%0d got=%0b exp=%0b", n, got_s, exp_s); end
      end
      checks++; if (o_sc_valid !== m_sc_valid) begin failures++; $display("FAIL rnd_sc_valid n=%0d got=%0b exp=%0b", n, o_sc_valid, m_sc_valid); end
      if (m_sc_valid) begin
        checks++; if (o_sc_result !== m_sc_result) begin failures++; $display("FAIL rnd_sc_result n=%0d got=%0h exp=%0h", n, o_sc_result, m_sc_result); end
      end
      checks++; if (o_link_valid !== m_linked) begin failures++; $display("FAIL rnd_link_valid n=%0d got=%0b exp=%0b", n, o_link_valid, m_linked); end
      checks++; if (o_link_addr !== m_addr) begin failures++; $display("FAIL rnd_link_addr n=%0d got=%0h exp=%0h", n, o_link_addr, m_addr); end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_match_pair();
    test_store_kill();
    test_timeout();
    test_ll_beats_timeout();
    test_flush();
    test_reset_mid_link();
    test_gating();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/llsc_unit.md
LLSC_UNIT -- requirements
Module: llsc_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH from mips_core.svh, the word-address width of the data path.
REQ-002 SHALL have parameter LINK_TIMEOUT, default 1023, the number of cycles after which a live link self-expires (0 = never expires).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_llsc_input  llsc_input_ifc.in  --  carries is_sw, lladdr_wr (LL), is_sc, wr_reg_val[31:0] (zero-extended effective address).
REQ-006 i_valid  input  1  EX stage op is real and advancing this cycle; all i_llsc_input fields are ignored when low.
REQ-007 i_flush  input  1  pipeline flush or exception; kills the link.
REQ-008 o_sc_valid  output  1  one-cycle pulse marking an SC result.
REQ-009 o_sc_result  output  32  rt write-back value for SC: 32'd1 on success, 32'd0 on failure.
REQ-010 o_sc_success  output  1  SC may commit its store; combinational for the current EX cycle.
REQ-011 o_link_valid  output  1  link state is LINKED.
REQ-012 o_link_addr  output  ADDR_WIDTH  registered link address.

Function
REQ-013 The unit SHALL implement a two-state FSM: UNLINKED and LINKED.
REQ-014 An accepted op SHALL be one with i_valid=1; the fields SHALL be decoded with priority i_flush > is_sc > lladdr_wr > is_sw.
REQ-015 Address matching SHALL compare wr_reg_val[ADDR_WIDTH-1:2] against o_link_addr[ADDR_WIDTH-1:2], i.e. at word granularity.
REQ-016 LL in any state: go to LINKED, latch wr_reg_val[ADDR_WIDTH-1:0] into o_link_addr, and clear the timeout counter.
REQ-017 SC: o_sc_success SHALL be asserted in the same cycle iff state is LINKED and the address matches.
REQ-018 SC, next cycle: o_sc_valid=1 and o_sc_result equal to the registered success value (latency 1).
REQ-019 SC, state update: go to UNLINKED regardless of outcome.
REQ-020 SW to a matching address while LINKED: go to UNLINKED; SW to a non-matching address SHALL leave the state unchanged.
REQ-021 i_flush=1 SHALL force UNLINKED on the next edge, independent of i_valid, and SHALL suppress o_sc_success in that cycle.
REQ-022 The timeout counter SHALL increment each cycle while LINKED.
REQ-023 When LINK_TIMEOUT≠0 and the counter reaches LINK_TIMEOUT, the unit SHALL go to UNLINKED; the counter SHALL saturate and never wrap.
REQ-024 If timeout expiry and an LL fall in the same cycle, the LL SHALL win: state LINKED, counter 0.
REQ-025 If SC and timeout expiry fall in the same cycle, the SC SHALL succeed if otherwise matching.
REQ-026 o_sc_success SHALL be 0 whenever i_valid=0 or is_sc=0.
REQ-027 o_sc_valid SHALL be low in every cycle not immediately following an accepted SC.
REQ-028 o_link_addr SHALL hold its value in UNLINKED.

Reset
REQ-029 On rst=1 at a clock edge, the state SHALL become UNLINKED, with o_link_addr=0, counter=0, o_sc_valid=0, o_sc_result=0.
REQ-030 Reset SHALL override every simultaneous op; an SC issued in the reset cycle SHALL produce no o_sc_valid pulse.
REQ-031 After rst deasserts, an SC SHALL fail until a new LL is accepted.

Structure
REQ-032 The FSM state enum (llsc_state_t) and LLSC_SC_OK/LLSC_SC_FAIL constants SHALL live in the shared mips_core package.
REQ-033 llsc_input_ifc SHALL remain defined in the shared interface file, unchanged.
REQ-034 The timeout counter SHALL be one sub-module, llsc_link_timer (inputs clear, enable; output expired), parameterised by LINK_TIMEOUT.

Verification
REQ-035 Matching pair: LL addr 0x0000_0100, then SC addr 0x0000_0100 two cycles later -> o_sc_success=1 in the SC cycle; next cycle o_sc_valid=1, o_sc_result=1; o_link_valid=0 afterwards.
REQ-036 Store kills link: LL 0x100, SW 0x102, SC 0x100 -> SC fails (o_sc_result=0); same sequence with SW 0x104 -> SC succeeds.
REQ-037 Timeout: LINK_TIMEOUT=4; LL 0x200, idle 4 cycles, SC 0x200 -> fail. Same test with 3 idle cycles -> succeed.
REQ-038 Flush: LL 0x300, i_flush pulse, SC 0x300 -> fail. Flush in the same cycle as an SC -> o_sc_success=0 in that cycle.
REQ-039 Reset mid-link: LL 0x400, rst for 1 cycle in the same cycle as an SC -> no o_sc_valid; link_valid=0; later SC 0x400 -> fail.
REQ-040 Gating: is_sc=1 with i_valid=0 while LINKED -> no o_sc_valid, and the state stays LINKED.
